// File: rtl/multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package multiplier_pkg;

  localparam int unsigned WordLengthDefault = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } seq_state_t;

endpackage

// File: rtl/multiplier_sequencer_if.sv
// Control handshake between the multiplier datapath (master) and its sequencer (slave).
interface multiplier_sequencer_if;

  logic Start;
  logic Shift_CA2;
  logic Multiplier_LSB;
  logic Load;
  logic Shift;
  logic Add_Enable;
  logic Apply_CA2;
  logic Ready;
  logic Done;

  modport master (
    output Start, Shift_CA2, Multiplier_LSB,
    input  Load, Shift, Add_Enable, Apply_CA2, Ready, Done
  );

  modport slave (
    input  Start, Shift_CA2, Multiplier_LSB,
    output Load, Shift, Add_Enable, Apply_CA2, Ready, Done
  );

endinterface

// File: rtl/iteration_counter.sv
// Shift-add iteration counter; tc_o flags the last iteration (count == Word_Length-1).
module iteration_counter #(
  parameter int unsigned Word_Length = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Word_Length + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CntW'(Word_Length - 1));

endmodule

// File: rtl/multiplier_sequencer.sv
// Control FSM for a sequential shift-add multiplier: load, Word_Length shift-add steps,
// optional two's-complement fix-up, then a one-cycle Done pulse.
module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter int unsigned Word_Length = WordLengthDefault
) (
  input logic                   clk,
  input logic                   rst,
  multiplier_sequencer_if.slave bus
);

  seq_state_t state_q, state_d;
  logic       ca2_q, ca2_d;
  logic       cnt_tc;

  iteration_counter #(
    .Word_Length (Word_Length)
  ) u_iteration_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == StLoad),
    .enable_i (state_q == StRun),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.Start) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (cnt_tc) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The sign-correction request is only meaningful while operands are being loaded.
  assign ca2_d = (state_q == StLoad) ? bus.Shift_CA2 : ca2_q;

  always_comb begin
    bus.Ready      = (state_q == StIdle);
    bus.Load       = (state_q == StLoad);
    bus.Shift      = (state_q == StRun);
    bus.Add_Enable = (state_q == StRun) & bus.Multiplier_LSB;
    bus.Apply_CA2  = (state_q == StFix) & ca2_q;
    bus.Done       = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ca2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ca2_q   <= ca2_d;
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench: directed cycle-exact scenarios plus randomized traffic vs. a cycle-count model.
module tb_multiplier_sequencer;

  localparam int unsigned WL = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  multiplier_sequencer_if bus ();

  multiplier_sequencer #(
    .Word_Length (WL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: k counts cycles since the operation's Start was accepted (0 = idle).
  int   k = 0;
  logic ca2_m = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k     <= 0;
      ca2_m <= 1'b0;
    end else begin
      if (k == 1) ca2_m <= bus.Shift_CA2;
      if (k == 0) k <= bus.Start ? 1 : 0;
      else if (k == WL + 3) k <= 0;
      else k <= k + 1;
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic run;
      run = (k >= 2) && (k <= WL + 1);
      chk("model_Ready", bus.Ready, k == 0);
      chk("model_Load", bus.Load, k == 1);
      chk("model_Shift", bus.Shift, run);
      chk("model_Add_Enable", bus.Add_Enable, run & bus.Multiplier_LSB);
      chk("model_Apply_CA2", bus.Apply_CA2, (k == WL + 2) & ca2_m);
      chk("model_Done", bus.Done, k == WL + 3);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Shift_CA2 = 1'b0;
    bus.Multiplier_LSB = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  // Literal expectations for cycle c of a directed scenario, sampled mid-cycle.
  task automatic check_cycle(input string tag, input int c, input logic e_ld, input logic e_sh,
                             input logic e_add, input logic e_ca2, input logic e_done,
                             input logic e_rdy);
    @(negedge clk);
    chk($sformatf("%s_c%0d_Load", tag, c), bus.Load, e_ld);
    chk($sformatf("%s_c%0d_Shift", tag, c), bus.Shift, e_sh);
    chk($sformatf("%s_c%0d_Add", tag, c), bus.Add_Enable, e_add);
    chk($sformatf("%s_c%0d_Apply", tag, c), bus.Apply_CA2, e_ca2);
    chk($sformatf("%s_c%0d_Done", tag, c), bus.Done, e_done);
    chk($sformatf("%s_c%0d_Ready", tag, c), bus.Ready, e_rdy);
    next_cycle();
  endtask

  initial begin
    logic [7:0] mult;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Shift_CA2 = 1'b0;
    bus.Multiplier_LSB = 1'b0;
    next_cycle();
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) check_cycle("idle", c, 0, 0, 0, 0, 0, 1);

    // Multiplier 0x05, second Start in cycle 5 must be ignored
    do_reset();
    mult = 8'h05;
    for (int c = 0; c <= 12; c++) begin
      bus.Start = (c == 0) || (c == 5);
      bus.Multiplier_LSB = (c >= 2 && c <= 9) ? mult[c-2] : 1'b0;
      check_cycle("mul05", c, c == 1, c >= 2 && c <= 9, c == 2 || c == 4, 0, c == 11,
                  c == 0 || c == 12);
    end

    // Sign correction latched in LOAD only; later toggles must not matter
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      bus.Start = (c == 0);
      bus.Shift_CA2 = (c == 1) || (c == 6);
      bus.Multiplier_LSB = (c == 2);
      check_cycle("ca2", c, c == 1, c >= 2 && c <= 9, c == 2, c == 10, c == 11,
                  c == 0 || c == 12);
    end
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      bus.Start = (c == 0);
      bus.Shift_CA2 = (c != 1);
      bus.Multiplier_LSB = 1'b0;
      check_cycle("noca2", c, c == 1, c >= 2 && c <= 9, 0, 0, c == 11, c == 0 || c == 12);
    end

    // Reset mid-RUN aborts without Done, then a full operation follows
    do_reset();
    bus.Shift_CA2 = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      bus.Start = (c == 0);
      rst = (c == 5);
      check_cycle("abort", c, c == 1, c >= 2 && c <= 5, 0, 0, 0, c == 0 || c >= 6);
    end
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      bus.Start = (c == 0);
      check_cycle("rerun", c, c == 1, c >= 2 && c <= 9, 0, 0, c == 11, c == 0 || c == 12);
    end

    // Start held high: back-to-back operations every WL+4 cycles
    do_reset();
    bus.Start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      check_cycle("held", c, c == 1 || c == 13, (c >= 2 && c <= 9) || (c >= 14 && c <= 21), 0, 0,
                  c == 11 || c == 23, c == 0 || c == 12 || c == 24);
    end
    bus.Start = 1'b0;

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      bus.Start = ($urandom_range(0, 3) == 0);
      bus.Shift_CA2 = 1'($urandom_range(0, 1));
      bus.Multiplier_LSB = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
